// File: rtl/mult_pipe_arb_pkg.sv
// mult_pipe_arb_pkg: shared defaults, issue tag type and requester ids
package mult_pipe_arb_pkg;
  localparam int WIDTH = 4;
  localparam int LATENCY = 4;
  localparam int FIFO_DEPTH = 4;
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;
  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;
endpackage

// File: rtl/mult_pipe_arbiter_if.sv
// mult_pipe_arbiter_if: requester, result and multiplier-port bundle
interface mult_pipe_arbiter_if #(parameter int WIDTH = mult_pipe_arb_pkg::WIDTH);
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b, mul_a, mul_b;
  logic [2*WIDTH-1:0] mul_p, res0_data, res1_data;
  logic res0_valid, res0_ready, res1_valid, res1_ready, busy;
  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res0_ready, res1_ready, mul_p,
    input req0_ready, req1_ready, res0_valid, res0_data, res1_valid, res1_data, mul_a, mul_b, busy
  );
  modport slave (
    input req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res0_ready, res1_ready, mul_p,
    output req0_ready, req1_ready, res0_valid, res0_data, res1_valid, res1_data, mul_a, mul_b, busy
  );
endinterface

// File: rtl/mult_pipe_arbiter_res_fifo.sv
// res_fifo: synchronous show-ahead result FIFO, head reads as zero when empty
module res_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] dout
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic do_pop;
  assign valid = count != '0;
  assign dout = valid ? mem[rp] : '0;
  assign do_pop = pop && valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp == AW'(DEPTH - 1) ? '0 : wp + 1'b1;
      if (do_pop) rp <= rp == AW'(DEPTH - 1) ? '0 : rp + 1'b1;
      count <= count + CW'(push) - CW'(do_pop);
      assert (!(push && !do_pop && count == CW'(DEPTH)));
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
endmodule

// File: rtl/mult_pipe_arbiter.sv
// mult_pipe_arbiter: two-requester credit-based share of a pipelined multiplier (MULT_PIPE_ARB_FIXED_PRIO_EN selects fixed priority)
module mult_pipe_arbiter #(
  parameter int WIDTH = mult_pipe_arb_pkg::WIDTH,
  parameter int LATENCY = mult_pipe_arb_pkg::LATENCY,
  parameter int FIFO_DEPTH = mult_pipe_arb_pkg::FIFO_DEPTH
) (
  input logic clk,
  input logic rst,
  mult_pipe_arbiter_if.slave bus
);
  import mult_pipe_arb_pkg::*;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  logic [CW-1:0] cnt0, cnt1;
  logic elig0, elig1, grant0, grant1, grant_any, gid, pop0, pop1, tag_busy;
  tag_t tag [LATENCY];
  tag_t ret;
  logic [2*WIDTH-1:0] ret_data;
  assign elig0 = bus.req0_valid && (cnt0 < CW'(FIFO_DEPTH));
  assign elig1 = bus.req1_valid && (cnt1 < CW'(FIFO_DEPTH));
`ifdef MULT_PIPE_ARB_FIXED_PRIO_EN
  assign grant0 = elig0;
`else
  logic last;
  assign grant0 = elig0 && (!elig1 || last == REQ1);
  always_ff @(posedge clk)
    if (rst) last <= REQ1;
    else if (grant_any) last <= gid;
`endif
  assign grant1 = elig1 && !grant0;
  assign grant_any = grant0 || grant1;
  assign gid = grant1 ? REQ1 : REQ0;
  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.mul_a = grant0 ? bus.req0_a : grant1 ? bus.req1_a : '0;
  assign bus.mul_b = grant0 ? bus.req0_b : grant1 ? bus.req1_b : '0;
  assign pop0 = bus.res0_valid && bus.res0_ready;
  assign pop1 = bus.res1_valid && bus.res1_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) tag[i] <= '0;
      ret <= '0;
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      tag[0] <= '{valid: grant_any, id: gid};
      for (int i = 1; i < LATENCY; i++) tag[i] <= tag[i-1];
      ret <= tag[LATENCY-1];
      cnt0 <= cnt0 + CW'(grant0) - CW'(pop0);
      cnt1 <= cnt1 + CW'(grant1) - CW'(pop1);
    end
  end
  always_ff @(posedge clk)
    ret_data <= bus.mul_p;
  always_comb begin
    tag_busy = ret.valid;
    for (int i = 0; i < LATENCY; i++) tag_busy = tag_busy || tag[i].valid;
  end
  assign bus.busy = tag_busy || bus.res0_valid || bus.res1_valid;
  res_fifo #(.W(2 * WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk(clk), .rst(rst), .push(ret.valid && ret.id == REQ0), .din(ret_data),
    .pop(bus.res0_ready), .valid(bus.res0_valid), .dout(bus.res0_data)
  );
  res_fifo #(.W(2 * WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk(clk), .rst(rst), .push(ret.valid && ret.id == REQ1), .din(ret_data),
    .pop(bus.res1_ready), .valid(bus.res1_valid), .dout(bus.res1_data)
  );
endmodule

// File: tb/tb_mult_pipe_arbiter.sv
// tb_mult_pipe_arbiter: random and directed traffic checked against a queue-based reference model
module tb_mult_pipe_arbiter;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int failures = 0;
  int ecnt = 0;
  mult_pipe_arbiter_if bus();
  mult_pipe_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;
  logic [7:0] p [mult_pipe_arb_pkg::LATENCY];
  always @(posedge clk) begin
    p[0] <= 8'(bus.mul_a) * 8'(bus.mul_b);
    for (int i = 1; i < mult_pipe_arb_pkg::LATENCY; i++) p[i] <= p[i-1];
  end
  assign bus.mul_p = p[mult_pipe_arb_pkg::LATENCY-1];
  typedef struct {
    int id;
    int prod;
    int due;
  } op_t;
  op_t fl[$];
  int q0[$];
  int q1[$];
  int last = 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cycle(input bit v0, input int a0, input int b0, input bit v1, input int a1, input int b1,
                       input bit r0, input bit r1);
    int o0, o1;
    bit e0, e1, g0, g1;
    @(negedge clk);
    bus.req0_valid = v0; bus.req0_a = 4'(a0); bus.req0_b = 4'(b0);
    bus.req1_valid = v1; bus.req1_a = 4'(a1); bus.req1_b = 4'(b1);
    bus.res0_ready = r0; bus.res1_ready = r1;
    #1;
    while (fl.size() > 0 && fl[0].due <= ecnt) begin
      if (fl[0].id == 0) q0.push_back(fl[0].prod);
      else q1.push_back(fl[0].prod);
      void'(fl.pop_front());
    end
    o0 = q0.size();
    o1 = q1.size();
    foreach (fl[i]) if (fl[i].id == 0) o0++; else o1++;
    e0 = v0 && o0 < 4;
    e1 = v1 && o1 < 4;
`ifdef MULT_PIPE_ARB_FIXED_PRIO_EN
    g0 = e0;
`else
    g0 = e0 && (!e1 || last == 1);
`endif
    g1 = e1 && !g0;
    chk("req0_ready", 32'(bus.req0_ready), 32'(g0));
    chk("req1_ready", 32'(bus.req1_ready), 32'(g1));
    chk("mul_a", 32'(bus.mul_a), 32'(g0 ? a0 : g1 ? a1 : 0));
    chk("mul_b", 32'(bus.mul_b), 32'(g0 ? b0 : g1 ? b1 : 0));
    chk("res0_valid", 32'(bus.res0_valid), 32'(q0.size() != 0));
    chk("res0_data", 32'(bus.res0_data), 32'(q0.size() != 0 ? q0[0] : 0));
    chk("res1_valid", 32'(bus.res1_valid), 32'(q1.size() != 0));
    chk("res1_data", 32'(bus.res1_data), 32'(q1.size() != 0 ? q1[0] : 0));
    chk("busy", 32'(bus.busy), 32'(fl.size() != 0 || q0.size() != 0 || q1.size() != 0));
    if (g0 || g1) begin
      fl.push_back('{id: int'(g1), prod: g1 ? a1 * b1 : a0 * b0, due: ecnt + 6});
      last = int'(g1);
    end
    if (r0 && q0.size() != 0) void'(q0.pop_front());
    if (r1 && q1.size() != 0) void'(q1.pop_front());
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.req0_a = 0; bus.req0_b = 0; bus.req1_a = 0; bus.req1_b = 0;
    bus.res0_ready = 0; bus.res1_ready = 0;
    @(negedge clk);
    rst = 0;
    fl.delete();
    q0.delete();
    q1.delete();
    last = 1;
  endtask
  task automatic idle(input int n, input bit r0, input bit r1);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, r0, r1);
  endtask
  initial begin
    do_reset();
    idle(1, 0, 0);
    cycle(1, 3, 5, 0, 0, 0, 0, 0);
    idle(5, 0, 0);
    idle(3, 1, 1);
    for (int i = 0; i < 20; i++) cycle(1, 15, 15, 1, 2, 7, 1, 1);
    idle(8, 1, 1);
    for (int i = 0; i < 12; i++) cycle(1, i % 16, 3, 1, 5, i % 16, 0, 1);
    for (int i = 0; i < 12; i++) cycle(1, 9, i % 16, 1, 4, 4, 1, 1);
    idle(8, 1, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 6, i + 1, 1, 1);
    idle(2, 1, 1);
    do_reset();
    idle(7, 1, 1);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, i + 2, 11, 1, 0);
    idle(6, 1, 0);
    idle(6, 1, 1);
    for (int i = 0; i < 10; i++) cycle(1, i + 1, 13, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) cycle(1, 14, i % 16, 0, 0, 0, 1, 1);
    idle(8, 1, 1);
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(99) < 70, $urandom_range(15), $urandom_range(15),
            $urandom_range(99) < 70, $urandom_range(15), $urandom_range(15),
            $urandom_range(99) < 60, $urandom_range(99) < 60);
    idle(15, 1, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
